// File: rtl/truth_table_sweeper_if.sv
// Bus interface for truth_table_sweeper: start/expected-table request,
// the single-bit DUT response and the sweep status/result signals.
// Optional macro STOP_ON_MISMATCH_EN adds the fail_idx result field.
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    logic                   start;
    logic [(1<<N_IN)-1:0]   exp_tt;
    logic                   dut_out;
    logic [N_IN-1:0]        vec;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [(1<<N_IN)-1:0]   captured;
    logic [N_IN:0]          mismatch_cnt;
`ifdef STOP_ON_MISMATCH_EN
    logic [N_IN-1:0]        fail_idx;
`endif

    // Controller / DUT side: requests sweeps, supplies the response.
    modport master (
        output start, exp_tt, dut_out,
        input  vec, busy, done, pass, captured, mismatch_cnt
`ifdef STOP_ON_MISMATCH_EN
        , input fail_idx
`endif
    );

    // Sweeper side.
    modport slave (
        input  start, exp_tt, dut_out,
        output vec, busy, done, pass, captured, mismatch_cnt
`ifdef STOP_ON_MISMATCH_EN
        , output fail_idx
`endif
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks all 2^N_IN input vectors in binary order,
// holding each for DWELL cycles, samples the DUT response on the last
// dwell cycle into a captured truth table and counts mismatches against
// an expected table latched at start.
// Optional macro STOP_ON_MISMATCH_EN: the first mismatching sample ends
// the sweep and its vector index is reported on fail_idx.
module truth_table_sweeper #(
    parameter int N_IN  = 4,
    parameter int DWELL = 62
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  sw
);
    localparam int NVEC = 1 << N_IN;
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [N_IN-1:0] LAST_IDX   = {N_IN{1'b1}};
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [NVEC-1:0]   exp_q, exp_d;
    logic [NVEC-1:0]   cap_q, cap_d;
    logic [N_IN:0]     mm_q, mm_d;
    logic              miss;
    logic              halt;
`ifdef STOP_ON_MISMATCH_EN
    logic [N_IN-1:0]   fidx_q, fidx_d;
`endif

    // Next-state and datapath updates for the sweep FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        exp_d   = exp_q;
        cap_d   = cap_q;
        mm_d    = mm_q;
        miss    = 1'b0;
        halt    = 1'b0;
`ifdef STOP_ON_MISMATCH_EN
        fidx_d  = fidx_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (sw.start) begin
                    exp_d   = sw.exp_tt;
                    cap_d   = '0;
                    mm_d    = '0;
                    idx_d   = '0;
                    dwell_d = '0;
`ifdef STOP_ON_MISMATCH_EN
                    fidx_d  = '0;
`endif
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    // Last dwell cycle: the DUT has settled on this vector.
                    miss         = (sw.dut_out != exp_q[idx_q]);
                    cap_d[idx_q] = sw.dut_out;
                    mm_d         = mm_q + (N_IN+1)'(miss);
                    dwell_d      = '0;
                    halt         = (idx_q == LAST_IDX);
`ifdef STOP_ON_MISMATCH_EN
                    if (miss) begin
                        fidx_d = idx_q;
                        halt   = 1'b1;
                    end
`endif
                    // idx never wraps: the final vector exits to DONE.
                    if (halt) state_d = DONE;
                    else      idx_d   = idx_q + N_IN'(1);
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the latched expected table and captured word are plain
        // registers, so they are reset like everything else; all outputs
        // read zero immediately on reset.
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            exp_q   <= '0;
            cap_q   <= '0;
            mm_q    <= '0;
`ifdef STOP_ON_MISMATCH_EN
            fidx_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates
            // from the same pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            mm_q    <= mm_d;
`ifdef STOP_ON_MISMATCH_EN
            fidx_q  <= fidx_d;
`endif
        end
    end

    assign sw.vec          = idx_q;
    assign sw.busy         = (state_q == DRIVE);
    assign sw.done         = (state_q == DONE);
    assign sw.pass         = (state_q == DONE) && (mm_q == '0);
    assign sw.captured     = cap_q;
    assign sw.mismatch_cnt = mm_q;
`ifdef STOP_ON_MISMATCH_EN
    assign sw.fail_idx     = fidx_q;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: two instances (N_IN=4/DWELL=4
// and N_IN=3/DWELL=1) are driven with fixed and random truth tables; the
// expected sweep result is pushed at start and popped by a monitor when
// done rises.
`timescale 1ns/1ps
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(4)) sa ();
    truth_table_sweeper_if #(.N_IN(3)) sb ();

    // Behavioural DUTs: the combinational function is its truth table.
    logic [15:0] dtt_a;
    logic [7:0]  dtt_b;
    assign sa.dut_out = dtt_a[sa.vec];
    assign sb.dut_out = dtt_b[sb.vec];

    truth_table_sweeper #(.N_IN(4), .DWELL(4)) u_a (.clk(clk), .rst_n(rst_n), .sw(sa));
    truth_table_sweeper #(.N_IN(3), .DWELL(1)) u_b (.clk(clk), .rst_n(rst_n), .sw(sb));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] cap;
        logic [4:0]  mm;
        logic        pass;
        logic [3:0]  fidx;
        logic [3:0]  vlast;
        int          lat;
        int          t0;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Reference: the captured table is the DUT table itself; mismatches are
    // the differing bits. With early stop, only bits up to the first
    // difference are sampled.
    function automatic exp_t model(input int nvec, input int dwell,
                                   input logic [15:0] dtt, input logic [15:0] ett,
                                   input int t0);
        exp_t e;
        int   n = nvec;
        e.cap  = '0;
        e.mm   = '0;
        e.fidx = '0;
        e.t0   = t0;
        for (int i = 0; i < nvec; i++) begin
            e.cap[i] = dtt[i];
            if (dtt[i] !== ett[i]) begin
                e.mm++;
`ifdef STOP_ON_MISMATCH_EN
                e.fidx = 4'(i);
                n      = i + 1;
                break;
`endif
            end
        end
        e.pass  = (e.mm == 0);
        e.vlast = 4'(n - 1);
        e.lat   = n * dwell + 1;
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e, input logic [15:0] cap,
                           input logic [4:0] mm, input logic ps, input logic [3:0] vl,
                           input int now);
        check({tag, " captured"}, cap, e.cap);
        check({tag, " mismatch_cnt"}, mm, e.mm);
        check({tag, " pass"}, ps, e.pass);
        check({tag, " vec at done"}, vl, e.vlast);
        check({tag, " done latency"}, now - e.t0, e.lat);
    endtask

    // Monitor A: pop and compare on the rising edge of done.
    logic done_pa = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (sa.done && !done_pa) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a unexpected done: got done=1, expected no sweep pending");
            end else begin
                e = qa.pop_front();
                compare("a", e, sa.captured, sa.mismatch_cnt, sa.pass, sa.vec, cyc);
`ifdef STOP_ON_MISMATCH_EN
                check("a fail_idx", sa.fail_idx, e.fidx);
`endif
            end
        end
        done_pa <= sa.done;
    end

    // Monitor B: same for the 3-input, single-cycle-dwell instance.
    logic done_pb = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (sb.done && !done_pb) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b unexpected done: got done=1, expected no sweep pending");
            end else begin
                e = qb.pop_front();
                compare("b", e, {8'h0, sb.captured}, {1'b0, sb.mismatch_cnt}, sb.pass,
                        {1'b0, sb.vec}, cyc);
`ifdef STOP_ON_MISMATCH_EN
                check("b fail_idx", {1'b0, sb.fail_idx}, e.fidx);
`endif
            end
        end
        done_pb <= sb.done;
    end

    // Issue a start on A (called at a negedge), then scramble exp_tt.
    task automatic start_a(input logic [15:0] dtt, input logic [15:0] ett);
        dtt_a     = dtt;
        sa.exp_tt = ett;
        qa.push_back(model(16, 4, dtt, ett, cyc));
        sa.start  = 1'b1;
        @(negedge clk);
        sa.start  = 1'b0;
        sa.exp_tt = 16'($urandom);
        check("a start busy", sa.busy, 1'b1);
        check("a start cleared", {sa.done, sa.pass, sa.vec, sa.mismatch_cnt, sa.captured}, '0);
    endtask

    task automatic start_b(input logic [7:0] dtt, input logic [7:0] ett);
        dtt_b     = dtt;
        sb.exp_tt = ett;
        qb.push_back(model(8, 1, {8'h0, dtt}, {8'h0, ett}, cyc));
        sb.start  = 1'b1;
        @(negedge clk);
        sb.start  = 1'b0;
        sb.exp_tt = 8'($urandom);
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!sa.done && n < 3000) begin @(negedge clk); n++; end
        if (!sa.done) begin
            checks++; errors++;
            $display("FAIL a done timeout: got done=0, expected done within 3000 cycles");
        end
        @(negedge clk);
    endtask

    task automatic wait_done_b();
        int n = 0;
        while (!sb.done && n < 100) begin @(negedge clk); n++; end
        if (!sb.done) begin
            checks++; errors++;
            $display("FAIL b done timeout: got done=0, expected done within 100 cycles");
        end
        @(negedge clk);
    endtask

    task automatic wait_vec_a(input logic [3:0] v);
        int n = 0;
        while (sa.vec != v && n < 200) begin @(negedge clk); n++; end
        if (sa.vec != v) begin
            checks++; errors++;
            $display("FAIL a vec wait: got vec=%0d, expected %0d", sa.vec, v);
        end
    endtask

    initial begin
        logic [15:0] d16;
        logic [15:0] e16;
        sa.start = 1'b0; sa.exp_tt = '0; dtt_a = 16'h8000;
        sb.start = 1'b0; sb.exp_tt = '0; dtt_b = 8'h7F;
        rst_n = 1'b0;
        #1;
        check("reset a outputs", {sa.busy, sa.done, sa.pass, sa.vec, sa.mismatch_cnt, sa.captured}, '0);
        check("reset b outputs", {sb.busy, sb.done, sb.pass, sb.vec, sb.mismatch_cnt, sb.captured}, '0);
`ifdef STOP_ON_MISMATCH_EN
        check("reset a fail_idx", sa.fail_idx, '0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: AND4, OR4 pass/fail, stop-mode corner tables.
        start_a(16'h8000, 16'h8000); wait_done_a();
        check("a done holds", {sa.done, sa.busy}, 2'b10);
        start_a(16'hFFFE, 16'hFFFE); wait_done_a();
        start_a(16'hFFFE, 16'h8000); wait_done_a();
        start_a(16'h8000, 16'h0000); wait_done_a();
        start_a(16'h8000, 16'h8001); wait_done_a();

        // Asynchronous reset mid-sweep at vector 7.
        start_a(16'h8000, 16'h8000);
        wait_vec_a(4'd7);
        #2 rst_n = 1'b0;
        #1;
        check("midsweep reset a", {sa.busy, sa.done, sa.pass, sa.vec, sa.mismatch_cnt, sa.captured}, '0);
        qa.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset idle", {sa.busy, sa.done}, 2'b00);
        start_a(16'h8000, 16'h8000); wait_done_a();

        // Start during sweep is ignored; latency still measured from first start.
        start_a(16'hFFFE, 16'hFFFE);
        wait_vec_a(4'd3);
        sa.start = 1'b1;
        @(negedge clk);
        sa.start = 1'b0;
        wait_done_a();

        // Randomised tables: exact, single-bit-off and fully random expectations.
        for (int i = 0; i < 8; i++) begin
            d16 = 16'($urandom);
            case (i % 3)
                0:       e16 = d16;
                1:       e16 = d16 ^ (16'h1 << $urandom_range(0, 15));
                default: e16 = 16'($urandom);
            endcase
            start_a(d16, e16);
            wait_done_a();
        end

        // DWELL=1, NAND3: one vector per cycle.
        start_b(8'h7F, 8'h7F);
        for (int i = 0; i < 8; i++) begin
            check("b vec sweep", {sb.busy, sb.vec}, {1'b1, 3'(i)});
            @(negedge clk);
        end
        wait_done_b();
        for (int i = 0; i < 3; i++) begin
            start_b(8'($urandom), 8'($urandom));
            wait_done_b();
        end

        check("scoreboard drained", qa.size() + qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end
endmodule
